// File: rtl/nodf_mon_pkg.sv
// Shared definitions for the ap_ctrl_hs/ap_ctrl_chain handshake monitor.
package nodf_mon_pkg;

  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned DEF_LAT_W = 32;

  localparam logic [DEF_LAT_W-1:0] LAT_INIT = '1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_CONT = 2'd2,
    ST_FINISHED  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter with enable and asynchronous clear.
module nodf_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/nodf_module_intf.sv
// Status monitor for one non-dataflow HLS block: tracks the ap_ctrl handshake,
// counts starts/completions/stalls and measures latency and start interval.
module nodf_module_intf
  import nodf_mon_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned LAT_W = DEF_LAT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] min_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic [LAT_W-1:0] last_ii,
  output logic             txn_pulse,
  output logic             finished,
  output logic             proto_err
);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] RUN       = ST_RUN;
  localparam logic [1:0] WAIT_CONT = ST_WAIT_CONT;
  localparam logic [1:0] FINISHED  = ST_FINISHED;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             start_ev;
  logic             done_ev;
  logic             stall_ev;
  logic             perr_ev;
  logic             timer_en;
  logic [LAT_W-1:0] timer;
  logic [LAT_W-1:0] start_ts;
  logic [LAT_W-1:0] lat_c;
  logic             have_start;

  // A start in IDLE behaves as if RUN began this cycle, so a same-cycle done
  // (combinational block) is handled by the same rules with zero latency.
  always_comb begin
    state_d  = state_q;
    start_ev = 1'b0;
    done_ev  = 1'b0;
    stall_ev = 1'b0;
    perr_ev  = 1'b0;
    if (state_q != FINISHED) begin
      start_ev = (state_q == IDLE) && ap_start;
      perr_ev  = (ap_ready && !ap_start)
              || ((state_q == IDLE) && ap_done && !ap_start)
              || ((state_q == WAIT_CONT) && !ap_done);
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            if (ap_done && ap_continue) begin
              done_ev = 1'b1;
            end else if (ap_done) begin
              stall_ev = 1'b1;
              state_d  = WAIT_CONT;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (ap_done && ap_continue) begin
            done_ev = 1'b1;
            state_d = IDLE;
          end else if (ap_done) begin
            stall_ev = 1'b1;
            state_d  = WAIT_CONT;
          end
        end
        WAIT_CONT: begin
          if (ap_continue) begin
            done_ev = 1'b1;
            state_d = IDLE;
          end else if (ap_done) begin
            stall_ev = 1'b1;
          end
        end
        default: ;
      endcase
      if (finish) begin
        state_d = FINISHED;
      end
    end
  end

  assign timer_en = (state_q != FINISHED);
  assign lat_c    = start_ev ? '0 : (timer - start_ts);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  nodf_sat_counter #(.W(LAT_W)) u_timer (
    .clock(clock), .reset(reset), .en(timer_en), .count(timer)
  );
  nodf_sat_counter #(.W(CNT_W)) u_start_cnt (
    .clock(clock), .reset(reset), .en(start_ev), .count(start_cnt)
  );
  nodf_sat_counter #(.W(CNT_W)) u_done_cnt (
    .clock(clock), .reset(reset), .en(done_ev), .count(done_cnt)
  );
  nodf_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock(clock), .reset(reset), .en(stall_ev), .count(stall_cnt)
  );

  // Timestamps and latency statistics; min_lat starts all ones so the first
  // completed transaction always replaces it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_ts   <= '0;
      have_start <= 1'b0;
      last_ii    <= '0;
      last_lat   <= '0;
      min_lat    <= {LAT_W{1'b1}};
      max_lat    <= '0;
      txn_pulse  <= 1'b0;
      finished   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      txn_pulse <= done_ev;
      if (perr_ev) begin
        proto_err <= 1'b1;
      end
      if (finish) begin
        finished <= 1'b1;
      end
      if (start_ev) begin
        start_ts   <= timer;
        have_start <= 1'b1;
        if (have_start) begin
          last_ii <= timer - start_ts;
        end
      end
      if (done_ev) begin
        last_lat <= lat_c;
        if (lat_c < min_lat) begin
          min_lat <= lat_c;
        end
        if (lat_c > max_lat) begin
          max_lat <= lat_c;
        end
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Self-checking bench: scenario tasks driving the handshake, checked against a
// transaction-level model (latency = done cycle - start cycle, ii = start gap).
module tb_nodf_module_intf;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_continue = 1'b0;
  logic        finish = 1'b0;
  logic [1:0]  state;
  logic [31:0] start_cnt, done_cnt, stall_cnt;
  logic [31:0] last_lat, min_lat, max_lat, last_ii;
  logic        txn_pulse, finished, proto_err;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int unsigned exp_sc, exp_dc, exp_stall, exp_lat, exp_min, exp_max, exp_ii;
  int          prev_start;

  nodf_module_intf dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .state(state), .start_cnt(start_cnt), .done_cnt(done_cnt),
    .stall_cnt(stall_cnt), .last_lat(last_lat), .min_lat(min_lat),
    .max_lat(max_lat), .last_ii(last_ii), .txn_pulse(txn_pulse),
    .finished(finished), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic model_init();
    exp_sc = 0; exp_dc = 0; exp_stall = 0; exp_lat = 0;
    exp_min = nodf_mon_pkg::LAT_INIT; exp_max = 0; exp_ii = 0;
    prev_start = -1;
    cyc = 0;
  endtask

  task automatic step(input logic s, input logic r, input logic d, input logic c, input logic f);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
    @(posedge clock); #1; cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b0; finish = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_init();
  endtask

  // One ap_ctrl transaction: start held until ready (with done) at cycle lat,
  // then stl cycles of ap_continue=0 before the downstream accepts.
  task automatic do_txn(input int lat, input int stl, input bit fin);
    int n;
    logic [1:0] st_e;
    n = lat + stl;
    for (int k = 0; k <= n; k++) begin
      step(k <= lat, k == lat, k >= lat, (k == n) || (stl == 0), fin && (k == n));
      if (k == 0) begin
        exp_sc++;
        if (prev_start >= 0) exp_ii = cyc - prev_start;
        prev_start = cyc;
      end
      if (k < n) begin
        st_e = (k < lat) ? 2'd1 : 2'd2;
        tests++;
        if (state !== st_e || txn_pulse !== 1'b0) begin
          fails++;
          $display("FAIL txn_mid k=%0d: state=%0d pulse=%0b, want state=%0d pulse=0", k, state, txn_pulse, st_e);
        end
      end else begin
        exp_dc++; exp_stall += stl; exp_lat = n;
        if (exp_lat < exp_min) exp_min = exp_lat;
        if (exp_lat > exp_max) exp_max = exp_lat;
        st_e = fin ? 2'd3 : 2'd0;
        tests++;
        if (state !== st_e || txn_pulse !== 1'b1 || last_lat !== exp_lat) begin
          fails++;
          $display("FAIL txn_end: state=%0d pulse=%0b last_lat=%0d, want state=%0d pulse=1 last_lat=%0d",
                   state, txn_pulse, last_lat, st_e, exp_lat);
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset state: got %0d want 0", state); end
    tests++; if ({start_cnt, done_cnt, stall_cnt} !== 96'd0) begin fails++; $display("FAIL reset counters: got %0d/%0d/%0d want 0", start_cnt, done_cnt, stall_cnt); end
    tests++; if ({last_lat, max_lat, last_ii} !== 96'd0) begin fails++; $display("FAIL reset meas: got %0d/%0d/%0d want 0", last_lat, max_lat, last_ii); end
    tests++; if (min_lat !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset min_lat: got %0h want ffffffff", min_lat); end
    tests++; if ({txn_pulse, finished, proto_err} !== 3'b000) begin fails++; $display("FAIL reset flags: got %03b want 000", {txn_pulse, finished, proto_err}); end
  endtask

  task automatic test_quiescent_finish();
    apply_reset();
    idle(49);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (state !== 2'd3 || finished !== 1'b1) begin fails++; $display("FAIL quiet finish: state=%0d finished=%0b want 3/1", state, finished); end
    tests++; if ({start_cnt, done_cnt, stall_cnt, last_lat, max_lat, last_ii} !== 192'd0) begin fails++; $display("FAIL quiet counters: sc=%0d dc=%0d st=%0d want 0", start_cnt, done_cnt, stall_cnt); end
    tests++; if (min_lat !== 32'hFFFF_FFFF || proto_err !== 1'b0) begin fails++; $display("FAIL quiet min/perr: %0h/%0b want ffffffff/0", min_lat, proto_err); end
  endtask

  task automatic test_single();
    apply_reset();
    idle(9);
    do_txn(7, 0, 1'b0);
    idle(1);
    tests++; if (txn_pulse !== 1'b0) begin fails++; $display("FAIL single pulse_after: got %0b want 0", txn_pulse); end
    tests++; if (last_lat !== 32'd7 || min_lat !== 32'd7 || max_lat !== 32'd7) begin fails++; $display("FAIL single lat: last=%0d min=%0d max=%0d want 7", last_lat, min_lat, max_lat); end
    tests++; if (done_cnt !== 32'd1 || start_cnt !== 32'd1 || last_ii !== 32'd0) begin fails++; $display("FAIL single counts: dc=%0d sc=%0d ii=%0d want 1/1/0", done_cnt, start_cnt, last_ii); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    idle(9);  do_txn(5, 0, 1'b0);
    idle(19 - cyc); do_txn(9, 0, 1'b0);
    idle(34 - cyc); do_txn(3, 0, 1'b0);
    do_txn(0, 0, 1'b0);
    tests++; if (min_lat !== 32'd0 || max_lat !== 32'd9) begin fails++; $display("FAIL b2b min/max: %0d/%0d want 0/9", min_lat, max_lat); end
    tests++; if (last_ii !== 32'd4 || exp_ii != 4) begin fails++; $display("FAIL b2b last_ii: got %0d want 4", last_ii); end
    tests++; if (start_cnt !== 32'd4 || done_cnt !== 32'd4) begin fails++; $display("FAIL b2b counts: %0d/%0d want 4/4", start_cnt, done_cnt); end
    tests++; if (state !== 2'd0 || proto_err !== 1'b0) begin fails++; $display("FAIL b2b state/perr: %0d/%0b want 0/0", state, proto_err); end
  endtask

  task automatic test_stall();
    apply_reset();
    idle(24);
    do_txn(5, 4, 1'b0);
    tests++; if (stall_cnt !== 32'd4) begin fails++; $display("FAIL stall cnt: got %0d want 4", stall_cnt); end
    tests++; if (last_lat !== 32'd9) begin fails++; $display("FAIL stall lat: got %0d want 9", last_lat); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL stall perr: got %0b want 0", proto_err); end
  endtask

  task automatic test_random();
    int lat, stl, gap;
    apply_reset();
    for (int t = 0; t < 25; t++) begin
      gap = int'($urandom_range(0, 4));
      lat = int'($urandom_range(0, 12));
      stl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      idle(gap);
      do_txn(lat, stl, 1'b0);
      tests++;
      if (start_cnt !== exp_sc || done_cnt !== exp_dc || stall_cnt !== exp_stall) begin
        fails++;
        $display("FAIL rand%0d counts: sc=%0d dc=%0d st=%0d want %0d/%0d/%0d", t, start_cnt, done_cnt, stall_cnt, exp_sc, exp_dc, exp_stall);
      end
      tests++;
      if (min_lat !== exp_min || max_lat !== exp_max || last_ii !== exp_ii) begin
        fails++;
        $display("FAIL rand%0d meas: min=%0d max=%0d ii=%0d want %0d/%0d/%0d", t, min_lat, max_lat, last_ii, exp_min, exp_max, exp_ii);
      end
    end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rand perr: got %0b want 0", proto_err); end
  endtask

  task automatic test_finish_with_done();
    apply_reset();
    idle(2);
    do_txn(3, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tests++; if (state !== 2'd3 || finished !== 1'b1) begin fails++; $display("FAIL fin state: %0d/%0b want 3/1", state, finished); end
    tests++; if (start_cnt !== 32'd1 || done_cnt !== 32'd1 || last_lat !== 32'd3) begin fails++; $display("FAIL fin freeze: sc=%0d dc=%0d lat=%0d want 1/1/3", start_cnt, done_cnt, last_lat); end
    tests++; if (txn_pulse !== 1'b0) begin fails++; $display("FAIL fin pulse: got %0b want 0", txn_pulse); end
  endtask

  task automatic test_proto_err();
    apply_reset();
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (proto_err !== 1'b1 || state !== 2'd0 || done_cnt !== 32'd0) begin fails++; $display("FAIL perr idle_done: perr=%0b state=%0d dc=%0d want 1/0/0", proto_err, state, done_cnt); end
    idle(2);
    tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL perr sticky: got %0b want 1", proto_err); end
    apply_reset();
    tests++; if (proto_err !== 1'b0 || min_lat !== 32'hFFFF_FFFF || state !== 2'd0) begin fails++; $display("FAIL perr reset: perr=%0b min=%0h state=%0d", proto_err, min_lat, state); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL perr ready_nostart: got %0b want 1", proto_err); end
    apply_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tests++; if (proto_err !== 1'b0 || state !== 2'd2) begin fails++; $display("FAIL perr wc_enter: perr=%0b state=%0d want 0/2", proto_err, state); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL perr done_drop: got %0b want 1", proto_err); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    idle(2);
    do_txn(2, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (state !== 2'd1 || start_cnt !== 32'd2) begin fails++; $display("FAIL arst pre: state=%0d sc=%0d want 1/2", state, start_cnt); end
    #3 reset = 1'b1;
    #1;
    tests++; if (state !== 2'd0 || start_cnt !== 32'd0 || done_cnt !== 32'd0) begin fails++; $display("FAIL arst async: state=%0d sc=%0d dc=%0d want 0", state, start_cnt, done_cnt); end
    tests++; if (last_lat !== 32'd0 || min_lat !== 32'hFFFF_FFFF || last_ii !== 32'd0) begin fails++; $display("FAIL arst meas: lat=%0d min=%0h ii=%0d", last_lat, min_lat, last_ii); end
    ap_start = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    model_init();
    idle(3);
    do_txn(4, 0, 1'b0);
    tests++; if (last_ii !== 32'd0 || start_cnt !== 32'd1 || min_lat !== 32'd4) begin fails++; $display("FAIL arst fresh: ii=%0d sc=%0d min=%0d want 0/1/4", last_ii, start_cnt, min_lat); end
  endtask

  initial begin
    model_init();
    test_reset();
    test_quiescent_finish();
    test_single();
    test_back_to_back();
    test_stall();
    test_random();
    test_finish_with_done();
    test_proto_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
